rr_arbiter_4: RTL
=================

Name: rr_arbiter_4

Overview:
Round-robin arbiter for four streaming sources feeding the shared MUX_4_1 datapath. It decides which source owns the mux and drives the mux SEL. It also runs the valid/ready handshake between the selected source and the single downstream consumer. An owner may keep the mux for a bounded burst before it is forced to rotate.

Parameters:
HOLD_MAX, 4, maximum consecutive transfers by one owner while another source is requesting; legal range 1..255.

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  synchronous reset, active-high
REQ  input  4  REQ[i] = source i presents valid data; must stay high until a transfer with GNT[i]
DST_READY  input  1  downstream consumer can accept data this cycle
SEL  output  2  owner index, drives MUX_4_1 SEL (0=A, 1=B, 2=C, 3=D)
VALID  output  1  muxed data is valid toward downstream
GNT  output  4  one-hot; GNT[i] = transfer from source i occurs this cycle
BUSY  output  1  arbiter holds an owner (state GRANT)

Behaviour:
- Reset (synchronous, RST=1 at clock edge):
  - state=IDLE, SEL=0, PTR=0, CNT=0.
  - VALID=0, GNT=0, BUSY=0 during and after the reset cycle.
  - Reset mid-burst drops ownership; no GNT is issued while RST=1.
- State IDLE:
  - VALID=0, GNT=0.
  - If REQ!=0, pick the first set bit scanning PTR, PTR+1, ... mod 4.
  - Register it as OWNER (SEL), set CNT=0, go to GRANT.
  - Latency: REQ rising to VALID is 1 cycle.
- State GRANT:
  - VALID = REQ[SEL], combinational from registered SEL.
  - GNT[SEL] = VALID & DST_READY; all other GNT bits are 0.
  - Transfer = VALID & DST_READY. On a transfer, CNT increments, saturating at HOLD_MAX.
- Release condition (evaluated each GRANT cycle):
  - (a) REQ[SEL]=0, or
  - (b) a transfer occurs that makes CNT reach HOLD_MAX while REQ has any bit other than SEL set.
- On release:
  - PTR = SEL+1 mod 4.
  - Re-arbitrate in the same cycle over REQ with the owner bit masked, scanning from SEL+1.
  - If a winner exists: SEL=winner, CNT=0, stay in GRANT (no idle bubble; new VALID on the next cycle).
  - Otherwise go to IDLE; SEL holds its last value.
- Transfer and release in the same cycle: the transfer completes (GNT pulses) first, then ownership moves.
- Sole requester never rotates: with REQ[SEL] the only request, CNT saturates and the owner keeps GRANT indefinitely.
- SEL changes only on a clock edge, never combinationally; the mux output is stable within a cycle.
- Width rules:
  - CNT width = clog2(HOLD_MAX+1).
  - PTR and SEL are 2 bits; wrap 3 -> 0 is natural modulo.
- DST_READY low: VALID stays asserted, GNT=0, CNT unchanged, no rotation by rule (b).

Decomposition:
- Shared constants include:
  - state encodings IDLE=1'b0, GRANT=1'b1;
  - SEL encodings SRC_A..SRC_D = 0..3;
  - source count 4.
- Sub-module rr_pick_4 (combinational):
  - inputs: 4-bit request mask, 2-bit start index;
  - outputs: 2-bit winner index, 1-bit found.
  - It is instantiated once and shared by the IDLE and release paths.

Test Plan:
1. Reset: RST=1 for 2 cycles with REQ=4'b1111 -> VALID=0, GNT=0, BUSY=0, SEL=0 throughout; after release, SEL=0 and VALID=1 one cycle later.
2. Single source: REQ=4'b0100, DST_READY=1 for 10 cycles -> SEL=2, GNT=4'b0100 every cycle from cycle 2, no rotation despite CNT saturating.
3. Fairness: REQ=4'b1111 constant, DST_READY=1, HOLD_MAX=4 -> owners 0,1,2,3,0 in order. Each gets exactly 4 GNT pulses, with zero bubble cycles between owners.
4. Backpressure: owner 1, DST_READY=0 for 5 cycles, REQ=4'b0011 -> VALID=1, GNT=0, SEL=1 held; CNT unchanged; resume with DST_READY=1 gives 4 transfers, then SEL=0.
5. Early drop: owner 3 drops REQ after 2 transfers, REQ[0]=1 -> next cycle SEL=0 (wrap 3->0), VALID=1; PTR=0.
6. Reset mid-burst: owner 2 after 2 transfers, RST=1 one cycle -> GNT=0 that cycle; restart arbitrates from PTR=0, so with REQ=4'b0101 SEL=0.

Source files
------------

// File: rtl/rr_arbiter_4_pkg.sv
// Shared types and constants for the four-source round-robin arbiter.
// Source indices match the MUX_4_1 select encoding.
package rr_arbiter_4_pkg;

   localparam int N_SRC = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   typedef enum logic [1:0] {
      SRC_A = 2'd0,
      SRC_B = 2'd1,
      SRC_C = 2'd2,
      SRC_D = 2'd3
   } src_t;

   function automatic logic [N_SRC-1:0] src_onehot(input logic [1:0] idx);
      return 4'b0001 << idx;
   endfunction

endpackage

// File: rtl/rr_pick_4.sv
// Rotating priority picker: the first set bit of i_req, scanning upward
// from i_start and wrapping modulo 4.
module rr_pick_4
   import rr_arbiter_4_pkg::*;
(
   input  logic [N_SRC-1:0] i_req,
   input  logic [1:0]       i_start,
   output logic [1:0]       o_win,
   output logic             o_found
);

   logic [1:0] w_idx;

   // Scan from the farthest offset down so the nearest request wins.
   always_comb begin
      o_win   = i_start;
      o_found = 1'b0;
      w_idx   = i_start;
      for (int k = N_SRC - 1; k >= 0; k--) begin
         w_idx = i_start + 2'(k);
         if (i_req[w_idx]) begin
            o_win   = w_idx;
            o_found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/rr_arbiter_4.sv
// Round-robin owner selection for a shared 4:1 mux, with valid/ready
// handshake to one consumer and a bounded burst per owner under contention.
module rr_arbiter_4
   import rr_arbiter_4_pkg::*;
#(
   parameter int HOLD_MAX = 4
)(
   input  logic             CLK,
   input  logic             RST,
   input  logic [N_SRC-1:0] REQ,
   input  logic             DST_READY,
   output logic [1:0]       SEL,
   output logic             VALID,
   output logic [N_SRC-1:0] GNT,
   output logic             BUSY
);

   localparam int            CW      = $clog2(HOLD_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(HOLD_MAX);

   // Handshake: a transfer happens in a cycle where VALID and DST_READY are
   // both high; the source must hold REQ until that cycle.
   state_t           r_state, w_state_nxt;
   logic [1:0]       r_sel, w_sel_nxt;
   logic [1:0]       r_ptr, w_ptr_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;

   logic [N_SRC-1:0] w_owner_oh;
   logic             w_grant;
   logic             w_valid;
   logic             w_xfer;
   logic [CW-1:0]    w_cnt_inc;
   logic             w_others;
   logic             w_release;
   logic [N_SRC-1:0] w_pick_req;
   logic [1:0]       w_pick_start;
   logic [1:0]       w_win;
   logic             w_found;

   assign w_owner_oh = src_onehot(r_sel);
   assign w_grant    = (r_state == ST_GRANT);
   assign w_valid    = w_grant & REQ[r_sel] & ~RST;
   assign w_xfer     = w_valid & DST_READY;
   assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);
   assign w_others   = |(REQ & ~w_owner_oh);
   assign w_release  = w_grant &
                       (~REQ[r_sel] | (w_xfer & (w_cnt_inc == CNT_MAX) & w_others));

   // One picker serves both the IDLE start and the hand-off on release.
   assign w_pick_req   = w_grant ? (REQ & ~w_owner_oh) : REQ;
   assign w_pick_start = w_grant ? (r_sel + 2'd1) : r_ptr;

   rr_pick_4 u_pick (
      .i_req   (w_pick_req),
      .i_start (w_pick_start),
      .o_win   (w_win),
      .o_found (w_found)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= ST_IDLE;
         r_sel   <= SRC_A;
         r_ptr   <= 2'd0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_sel   <= w_sel_nxt;
         r_ptr   <= w_ptr_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sel_nxt   = r_sel;
      w_ptr_nxt   = r_ptr;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_sel_nxt   = w_win;
               w_cnt_nxt   = '0;
               w_state_nxt = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (w_release) begin
               w_ptr_nxt = r_sel + 2'd1;
               if (w_found) begin
                  w_sel_nxt = w_win;
                  w_cnt_nxt = '0;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end else if (w_xfer) begin
               w_cnt_nxt = w_cnt_inc;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      SEL   = r_sel;
      VALID = w_valid;
      GNT   = w_xfer ? w_owner_oh : '0;
      BUSY  = w_grant & ~RST;
   end

endmodule
